// File: rtl/trap_sequencer_pkg.sv
// Shared types, CSR addresses and mstatus helpers for the machine-mode trap sequencer.
package trap_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_EPC,
    ST_W_CAUSE,
    ST_W_TVAL,
    ST_W_STATUS,
    ST_REDIRECT,
    ST_MRET_STATUS,
    ST_MRET_REDIR
  } trap_state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] M_TIMER_INT = 32'h8000_0007;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // mstatus on trap entry: stack MIE into MPIE, disable interrupts, record M-mode.
  function automatic logic [31:0] trap_entry_status(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // mstatus on MRET: restore MIE from MPIE, set MPIE, stay in M-mode.
  function automatic logic [31:0] mret_exit_status(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_sequencer_target_calc.sv
// Handler address from mtvec: direct base, or base + 4*cause for vectored interrupts.
module trap_target_calc #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        is_int_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] cause_i,
  output logic [31:0] target_o
);
  import trap_sequencer_pkg::*;

  logic [31:0] base;

  always_comb begin
    base     = mtvec_i & PC_ALIGN_MASK;
    target_o = base;
    // The shift drops cause[31:30], matching 4*cause[30:0] truncated to 32 bits.
    if (VECTORED_EN && is_int_i && (mtvec_i[1:0] == 2'b01)) begin
      target_o = base + (cause_i << 2);
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET controller: serialises CSR writes, stalls/flushes the pipe, redirects fetch.
module trap_sequencer #(
  parameter bit          VECTORED_EN  = 1'b1,
  parameter logic [31:0] MTVAL_ON_INT = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instValid_i,
  input  logic [31:0] pc_i,
  input  logic        excPresent_i,
  input  logic [31:0] excCause_i,
  input  logic [31:0] trapInfo_i,
  input  logic        mret_i,
  input  logic        mtip_i,
  input  logic        mtie_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        csrWe_o,
  output logic [11:0] csrAddr_o,
  output logic [31:0] csrWdata_o,
  output logic        pcRedirect_o,
  output logic [31:0] pcTarget_o,
  output logic        trapActive_o
);
  import trap_sequencer_pkg::*;

  trap_state_t state_q, state_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic [31:0] saved_cause_q, saved_cause_d;
  logic [31:0] saved_tval_q, saved_tval_d;
  logic [31:0] saved_status_q, saved_status_d;
  logic        is_int_q, is_int_d;

  logic        int_req;
  logic [31:0] trap_target;

  assign int_req = mstatus_i[MSTATUS_MIE] & mtie_i & mtip_i;

  trap_target_calc #(
    .VECTORED_EN(VECTORED_EN)
  ) u_target (
    .is_int_i (is_int_q),
    .mtvec_i  (mtvec_i),
    .cause_i  (saved_cause_q),
    .target_o (trap_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      saved_pc_q     <= '0;
      saved_cause_q  <= '0;
      saved_tval_q   <= '0;
      saved_status_q <= '0;
      is_int_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      saved_pc_q     <= saved_pc_d;
      saved_cause_q  <= saved_cause_d;
      saved_tval_q   <= saved_tval_d;
      saved_status_q <= saved_status_d;
      is_int_q       <= is_int_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    saved_pc_d     = saved_pc_q;
    saved_cause_d  = saved_cause_q;
    saved_tval_d   = saved_tval_q;
    saved_status_d = saved_status_q;
    is_int_d       = is_int_q;
    stall_o        = (state_q != ST_IDLE);
    flush_o        = 1'b0;
    csrWe_o        = 1'b0;
    csrAddr_o      = '0;
    csrWdata_o     = '0;
    pcRedirect_o   = 1'b0;
    pcTarget_o     = '0;
    trapActive_o   = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        // Gating on rst keeps every output quiet while reset is held.
        if (!rst && instValid_i && (excPresent_i || int_req || mret_i)) begin
          stall_o        = 1'b1;
          flush_o        = 1'b1;
          trapActive_o   = 1'b1;
          saved_status_d = mstatus_i;
          if (excPresent_i) begin
            saved_pc_d    = pc_i;
            saved_cause_d = excCause_i;
            saved_tval_d  = trapInfo_i;
            is_int_d      = 1'b0;
            state_d       = ST_W_EPC;
          end else if (int_req) begin
            saved_pc_d    = pc_i;
            saved_cause_d = M_TIMER_INT;
            saved_tval_d  = MTVAL_ON_INT;
            is_int_d      = 1'b1;
            state_d       = ST_W_EPC;
          end else begin
            state_d       = ST_MRET_STATUS;
          end
        end
      end
      ST_W_EPC: begin
        csrWe_o    = 1'b1;
        csrAddr_o  = CSR_MEPC;
        csrWdata_o = saved_pc_q & PC_ALIGN_MASK;
        state_d    = ST_W_CAUSE;
      end
      ST_W_CAUSE: begin
        csrWe_o    = 1'b1;
        csrAddr_o  = CSR_MCAUSE;
        csrWdata_o = saved_cause_q;
        state_d    = ST_W_TVAL;
      end
      ST_W_TVAL: begin
        csrWe_o    = 1'b1;
        csrAddr_o  = CSR_MTVAL;
        csrWdata_o = saved_tval_q;
        state_d    = ST_W_STATUS;
      end
      ST_W_STATUS: begin
        csrWe_o    = 1'b1;
        csrAddr_o  = CSR_MSTATUS;
        csrWdata_o = trap_entry_status(saved_status_q);
        state_d    = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        pcRedirect_o = 1'b1;
        pcTarget_o   = trap_target;
        state_d      = ST_IDLE;
      end
      ST_MRET_STATUS: begin
        csrWe_o    = 1'b1;
        csrAddr_o  = CSR_MSTATUS;
        csrWdata_o = mret_exit_status(saved_status_q);
        state_d    = ST_MRET_REDIR;
      end
      ST_MRET_REDIR: begin
        pcRedirect_o = 1'b1;
        pcTarget_o   = mepc_i & PC_ALIGN_MASK;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed and random events against a cycle-list model.
module tb_trap_sequencer;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        redir;
    logic [31:0] tgt;
    logic        active;
  } obs_t;

  typedef struct packed {
    logic        valid;
    logic        exc;
    logic        mret;
    logic        mtip;
    logic        mtie;
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [31:0] mst;
    logic [31:0] mtvec;
    logic [31:0] mepc;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        instValid_i, excPresent_i, mret_i, mtip_i, mtie_i;
  logic [31:0] pc_i, excCause_i, trapInfo_i, mstatus_i, mtvec_i, mepc_i;

  logic        stall_v, flush_v, we_v, redir_v, active_v;
  logic [11:0] addr_v;
  logic [31:0] wdata_v, tgt_v;
  logic        stall_n, flush_n, we_n, redir_n, active_n;
  logic [11:0] addr_n;
  logic [31:0] wdata_n, tgt_n;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  obs_t exp_v[$];
  obs_t exp_nv[$];

  always #5 clk = ~clk;

  trap_sequencer #(.VECTORED_EN(1'b1), .MTVAL_ON_INT(32'h0)) dut (
    .clk(clk), .rst(rst), .instValid_i(instValid_i), .pc_i(pc_i),
    .excPresent_i(excPresent_i), .excCause_i(excCause_i), .trapInfo_i(trapInfo_i),
    .mret_i(mret_i), .mtip_i(mtip_i), .mtie_i(mtie_i), .mstatus_i(mstatus_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .stall_o(stall_v), .flush_o(flush_v),
    .csrWe_o(we_v), .csrAddr_o(addr_v), .csrWdata_o(wdata_v),
    .pcRedirect_o(redir_v), .pcTarget_o(tgt_v), .trapActive_o(active_v));

  trap_sequencer #(.VECTORED_EN(1'b0), .MTVAL_ON_INT(32'h0)) dut_nv (
    .clk(clk), .rst(rst), .instValid_i(instValid_i), .pc_i(pc_i),
    .excPresent_i(excPresent_i), .excCause_i(excCause_i), .trapInfo_i(trapInfo_i),
    .mret_i(mret_i), .mtip_i(mtip_i), .mtie_i(mtie_i), .mstatus_i(mstatus_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .stall_o(stall_n), .flush_o(flush_n),
    .csrWe_o(we_n), .csrAddr_o(addr_n), .csrWdata_o(wdata_n),
    .pcRedirect_o(redir_n), .pcTarget_o(tgt_n), .trapActive_o(active_n));

  function automatic obs_t obs_v();
    return {stall_v, flush_v, we_v, addr_v, wdata_v, redir_v, tgt_v, active_v};
  endfunction

  function automatic obs_t obs_nv();
    return {stall_n, flush_n, we_n, addr_n, wdata_n, redir_n, tgt_n, active_n};
  endfunction

  function automatic stim_t blank();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Reference model: list of per-cycle outputs from the accept cycle back to idle.
  task automatic predict(input stim_t s);
    obs_t r;
    logic is_int;
    logic [31:0] base, c, t, st;
    logic [11:0] addrs[4];
    logic [31:0] datas[4];
    exp_v.delete();
    exp_nv.delete();
    is_int = s.mst[3] && s.mtie && s.mtip && !s.exc;
    base   = {s.mtvec[31:2], 2'b00};
    if (!s.valid || !(s.exc || is_int || s.mret)) begin
      exp_v.push_back('0);
      exp_nv.push_back('0);
      return;
    end
    r = '0; r.stall = 1'b1; r.flush = 1'b1; r.active = 1'b1;
    exp_v.push_back(r); exp_nv.push_back(r);
    if (s.exc || is_int) begin
      c  = s.exc ? s.cause : 32'h8000_0007;
      t  = s.exc ? s.tval : 32'h0;
      st = (s.mst & ~32'h0000_1888) | 32'h0000_1800 | (s.mst[3] ? 32'h80 : 32'h0);
      addrs = '{12'h341, 12'h342, 12'h343, 12'h300};
      datas = '{{s.pc[31:2], 2'b00}, c, t, st};
      for (int k = 0; k < 4; k++) begin
        r = '0; r.stall = 1'b1; r.active = 1'b1; r.we = 1'b1;
        r.addr = addrs[k]; r.wdata = datas[k];
        exp_v.push_back(r); exp_nv.push_back(r);
      end
      r = '0; r.stall = 1'b1; r.active = 1'b1; r.redir = 1'b1; r.tgt = base;
      exp_nv.push_back(r);
      if (is_int && s.mtvec[1:0] == 2'b01) r.tgt = base + 32'(c[30:0]) * 32'd4;
      exp_v.push_back(r);
    end else begin
      st = (s.mst & ~32'h0000_1888) | 32'h0000_1880 | (s.mst[7] ? 32'h8 : 32'h0);
      r = '0; r.stall = 1'b1; r.active = 1'b1; r.we = 1'b1; r.addr = 12'h300; r.wdata = st;
      exp_v.push_back(r); exp_nv.push_back(r);
      r = '0; r.stall = 1'b1; r.active = 1'b1; r.redir = 1'b1; r.tgt = {s.mepc[31:2], 2'b00};
      exp_v.push_back(r); exp_nv.push_back(r);
    end
    exp_v.push_back('0);
    exp_nv.push_back('0);
  endtask

  task automatic apply(input stim_t s);
    instValid_i = s.valid; excPresent_i = s.exc; mret_i = s.mret;
    mtip_i = s.mtip; mtie_i = s.mtie; pc_i = s.pc; excCause_i = s.cause;
    trapInfo_i = s.tval; mstatus_i = s.mst; mtvec_i = s.mtvec; mepc_i = s.mepc;
  endtask

  // Scramble everything the sequencer should ignore mid-sequence; mtvec/mepc stay live.
  task automatic garbage(input bit last);
    instValid_i  = last ? 1'b0 : 1'($urandom_range(0, 1));
    excPresent_i = 1'($urandom_range(0, 1));
    mret_i       = 1'($urandom_range(0, 1));
    mtip_i       = 1'($urandom_range(0, 1));
    mtie_i       = 1'($urandom_range(0, 1));
    pc_i         = $urandom();
    excCause_i   = $urandom();
    trapInfo_i   = $urandom();
    mstatus_i    = $urandom();
  endtask

  task automatic test_reset();
    stim_t s;
    s = blank(); s.valid = 1'b1; s.exc = 1'b1; s.cause = 32'd2; s.pc = 32'h80;
    rst = 1'b1;
    apply(s);
    @(negedge clk);
    tests_run++;
    if (obs_v() !== obs_t'(0) || obs_nv() !== obs_t'(0)) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h / %h want 0", obs_v(), obs_nv());
    end
    @(posedge clk); #1;
    rst = 1'b0; instValid_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (obs_v() !== obs_t'(0) || obs_nv() !== obs_t'(0)) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got %h / %h want 0", obs_v(), obs_nv());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exception();
    stim_t s;
    s = blank(); s.valid = 1'b1; s.exc = 1'b1; s.pc = 32'h100; s.cause = 32'd5;
    s.tval = 32'hDEAD_0000; s.mst = 32'h8; s.mtvec = 32'h200;
    predict(s);
    apply(s);
    for (int i = 0; i < exp_v.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; garbage(i == exp_v.size() - 1); end
      @(negedge clk);
      tests_run++;
      if (obs_v() !== exp_v[i] || obs_nv() !== exp_nv[i]) begin
        tests_failed++;
        $display("FAIL exception cyc %0d: got %h/%h want %h/%h", i, obs_v(), obs_nv(), exp_v[i], exp_nv[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_interrupt();
    stim_t s;
    s = blank(); s.valid = 1'b1; s.mtip = 1'b1; s.mtie = 1'b1; s.pc = 32'h40;
    s.mst = 32'h8; s.mtvec = 32'h201; s.cause = 32'd9; s.tval = 32'h1234;
    predict(s);
    apply(s);
    for (int i = 0; i < exp_v.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; garbage(i == exp_v.size() - 1); end
      @(negedge clk);
      tests_run++;
      if (obs_v() !== exp_v[i] || obs_nv() !== exp_nv[i]) begin
        tests_failed++;
        $display("FAIL interrupt cyc %0d: got %h/%h want %h/%h", i, obs_v(), obs_nv(), exp_v[i], exp_nv[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    stim_t s;
    s = blank(); s.valid = 1'b1; s.exc = 1'b1; s.mret = 1'b1; s.mtip = 1'b1; s.mtie = 1'b1;
    s.pc = 32'h306; s.cause = 32'd2; s.tval = 32'hCAFE; s.mst = 32'h88; s.mtvec = 32'h401;
    s.mepc = 32'h999;
    predict(s);
    apply(s);
    for (int i = 0; i < exp_v.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; garbage(i == exp_v.size() - 1); end
      @(negedge clk);
      tests_run++;
      if (obs_v() !== exp_v[i] || obs_nv() !== exp_nv[i]) begin
        tests_failed++;
        $display("FAIL priority cyc %0d: got %h/%h want %h/%h", i, obs_v(), obs_nv(), exp_v[i], exp_nv[i]);
      end
    end
    @(posedge clk); #1;
    // Interrupt masked by MIE=0, then pending but no valid instruction.
    for (int k = 0; k < 2; k++) begin
      s = blank(); s.valid = (k == 0); s.mtip = 1'b1; s.mtie = 1'b1;
      s.mst = (k == 0) ? 32'h80 : 32'h8; s.mtvec = 32'h201;
      apply(s);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        tests_run++;
        if (obs_v() !== obs_t'(0) || obs_nv() !== obs_t'(0)) begin
          tests_failed++;
          $display("FAIL no_accept case %0d cyc %0d: got %h/%h want 0", k, c, obs_v(), obs_nv());
        end
        @(posedge clk); #1;
      end
    end
    instValid_i = 1'b0;
  endtask

  task automatic test_mret();
    stim_t s;
    s = blank(); s.valid = 1'b1; s.mret = 1'b1; s.mst = 32'h80; s.mepc = 32'h104;
    s.mtvec = 32'h200;
    predict(s);
    apply(s);
    for (int i = 0; i < exp_v.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; garbage(i == exp_v.size() - 1); end
      @(negedge clk);
      tests_run++;
      if (obs_v() !== exp_v[i] || obs_nv() !== exp_nv[i]) begin
        tests_failed++;
        $display("FAIL mret cyc %0d: got %h/%h want %h/%h", i, obs_v(), obs_nv(), exp_v[i], exp_nv[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    stim_t s;
    s = blank(); s.valid = 1'b1; s.exc = 1'b1; s.pc = 32'h500; s.cause = 32'd7;
    s.tval = 32'h77; s.mst = 32'h8; s.mtvec = 32'h600;
    predict(s);
    apply(s);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; garbage(1'b0); end
      if (i == 2) rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (obs_v() !== exp_v[i] || obs_nv() !== exp_nv[i]) begin
        tests_failed++;
        $display("FAIL reset_mid cyc %0d: got %h/%h want %h/%h", i, obs_v(), obs_nv(), exp_v[i], exp_nv[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    garbage(1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (obs_v() !== obs_t'(0) || obs_nv() !== obs_t'(0)) begin
        tests_failed++;
        $display("FAIL reset_mid_after cyc %0d: got %h/%h want 0", c, obs_v(), obs_nv());
      end
      @(posedge clk); #1;
      garbage(1'b1);
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int n = 0; n < 60; n++) begin
      s.valid = ($urandom_range(0, 3) != 0);
      s.exc   = ($urandom_range(0, 2) == 0);
      s.mret  = ($urandom_range(0, 2) == 0);
      s.mtip  = 1'($urandom_range(0, 1));
      s.mtie  = 1'($urandom_range(0, 1));
      s.pc    = $urandom();
      s.cause = $urandom();
      s.tval  = $urandom();
      s.mst   = $urandom();
      s.mtvec = $urandom();
      s.mepc  = $urandom();
      predict(s);
      apply(s);
      for (int i = 0; i < exp_v.size(); i++) begin
        if (i > 0) begin @(posedge clk); #1; garbage(i == exp_v.size() - 1); end
        @(negedge clk);
        tests_run++;
        if (obs_v() !== exp_v[i] || obs_nv() !== exp_nv[i]) begin
          tests_failed++;
          $display("FAIL random ev %0d cyc %0d: got %h/%h want %h/%h", n, i, obs_v(), obs_nv(), exp_v[i], exp_nv[i]);
        end
      end
      @(posedge clk); #1;
      instValid_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    apply(blank());
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_exception();
    test_interrupt();
    test_priority();
    test_mret();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
Multi-cycle machine-mode trap and MRET controller for the single-issue core. It consumes the exception detector's excPresent/excCause/trapInfo result, the timer-interrupt pending state and the MRET decode. It sequences the single-port CSR file writes (mepc, mcause, mtval, mstatus), stalls and flushes the pipeline, and redirects fetch to the mtvec handler or back to mepc.

Parameters:
VECTORED_EN, 1, honour mtvec MODE=1 (vectored) for interrupts; 0 = always direct
MTVAL_ON_INT, 0, value written to mtval on interrupts (constant)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
instValid_i  in  1  instruction in execute stage is valid and may commit
pc_i  in  32  PC of instruction in execute stage
excPresent_i  in  1  synchronous exception flagged for current instruction
excCause_i  in  32  exception cause code
trapInfo_i  in  32  faulting PC/address for mtval
mret_i  in  1  current instruction is MRET
mtip_i  in  1  machine timer interrupt pending
mtie_i  in  1  mie.MTIE
mstatus_i  in  32  current mstatus value
mtvec_i  in  32  current mtvec value
mepc_i  in  32  current mepc value
stall_o  out  1  freeze fetch/decode/execute
flush_o  out  1  kill instruction in execute (no writeback/store)
csrWe_o  out  1  CSR write enable
csrAddr_o  out  12  CSR write address
csrWdata_o  out  32  CSR write data
pcRedirect_o  out  1  load fetch PC with pcTarget_o
pcTarget_o  out  32  redirect target
trapActive_o  out  1  high from accept until redirect (debug/perf)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; every output 0; captured regs (savedPc, savedCause, savedTval, savedStatus, isInt) cleared.
- Reset asserted mid-sequence: next edge returns to IDLE; no further CSR writes or redirect; partial CSR writes are not undone.
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIRECT, MRET_STATUS, MRET_REDIR.
- Accept decision, IDLE only, when instValid_i=1. Priority: exception > interrupt > MRET.
  - Exception: excPresent_i.
  - Interrupt: mstatus_i[3] (MIE) & mtie_i & mtip_i.
  - MRET: mret_i.
- Accept cycle N (combinational outputs): flush_o=1 and stall_o=1. For exception/interrupt, the execute instruction is killed. For MRET, the instruction is considered retired.
- Capture at edge N:
  - Exception: savedPc=pc_i, savedCause=excCause_i, savedTval=trapInfo_i, isInt=0.
  - Interrupt: savedPc=pc_i (instruction not executed), savedCause=32'h8000_0007, savedTval=MTVAL_ON_INT, isInt=1.
  - savedStatus=mstatus_i in both cases.
- Trap path, one CSR write per cycle with csrWe_o=1:
  - N+1 W_EPC: 0x341 <= {savedPc[31:2],2'b00}.
  - N+2 W_CAUSE: 0x342 <= savedCause.
  - N+3 W_TVAL: 0x343 <= savedTval.
  - N+4 W_STATUS: 0x300 <= savedStatus with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
  - N+5 REDIRECT: pcRedirect_o=1, csrWe_o=0. Target:
    - isInt & VECTORED_EN & mtvec_i[1:0]==2'b01: {mtvec_i[31:2],2'b00} + 4*savedCause[30:0], truncated to 32 bits.
    - Otherwise: {mtvec_i[31:2],2'b00}.
  - N+6 IDLE.
- MRET path:
  - N+1 MRET_STATUS: 0x300 <= savedStatus with MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11.
  - N+2 MRET_REDIR: pcRedirect_o=1, pcTarget_o={mepc_i[31:2],2'b00}.
  - N+3 IDLE.
- stall_o=1 in every non-IDLE state. trapActive_o=1 in non-IDLE states and on the accept cycle.
- When not writing: csrWe_o=0, csrAddr_o=0, csrWdata_o=0. When not redirecting: pcTarget_o=0.
- Inputs are ignored outside IDLE; no nesting. Interrupts become visible again only after return to IDLE.
- instValid_i=0 in IDLE: no action; pending interrupt waits.

Decomposition:
- Shared package: trap_state_t enum; CSR_MSTATUS=12'h300, CSR_MEPC=12'h341, CSR_MCAUSE=12'h342, CSR_MTVAL=12'h343; M_TIMER_INT=32'h8000_0007; mstatus bit positions MIE=3, MPIE=7, MPP=12:11.
- One sub-module, trap_target_calc: pure combinational mtvec mode decode and vector-offset add.

Test Plan:
- Exception, load access fault: pc=0x100, excCause=5, trapInfo=0xDEAD0000, mstatus=0x8, mtvec=0x200 -> writes 0x341=0x100, 0x342=5, 0x343=0xDEAD0000, 0x300=0x1880 on N+1..N+4; redirect to 0x200 at N+5; stall N..N+5.
- Timer interrupt, vectored: mstatus=0x8, mtie=mtip=1, mtvec=0x201, pc=0x40 -> mcause=0x80000007, mtval=0, target=0x21C. Repeat with VECTORED_EN=0 -> target=0x200.
- Priority: excPresent=1, mtip/mtie/MIE=1, mret=1 in same cycle -> exception path taken, mcause=excCause. Interrupt masked with MIE=0 -> no action.
- MRET: mstatus=0x80, mepc=0x104 -> 0x300 written with 0x1888 at N+1; redirect to 0x104 at N+2; IDLE at N+3.
- Reset at W_CAUSE -> next cycle IDLE, all outputs 0, no mtval/mstatus write, no redirect.
- Inputs toggling during sequence (second excPresent at N+2) -> ignored; exactly 4 CSR writes and 1 redirect.
